// File: rtl/bus_pkg.sv
// Shared definitions for the memory bus arbiter: FSM encoding, default widths
// and requester port indices.
package bus_pkg;

  localparam int AW_DEF = 13;
  localparam int DW_DEF = 8;

  localparam int P_CPU  = 0;
  localparam int P_LOAD = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: a lone request wins outright, a tie goes to
// the port that did not own the previous access.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_owner_i,
  output logic [1:0] pick_o
);

  always_comb begin
    pick_o = req_i;
    if (req_i == 2'b11) begin
      pick_o = last_owner_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the CPU bus (port 0) and the loader/DMA
// (port 1), with programmable wait states and a one-cycle ack per access.
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [1:0]    gnt,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic          owner_q;
  logic          we_q;
  logic          last_owner_q;
  logic [1:0]    gnt_q;
  logic          mem_rd_q;
  logic          mem_wr_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          ack0_q;
  logic          ack1_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;

  logic [1:0]    pick_d;
  logic          sel_we_d;
  logic [AW-1:0] sel_addr_d;
  logic [DW-1:0] sel_wdata_d;

  // Arbitration only matters in IDLE; the FSM ignores pick_d elsewhere.
  rr_pick2 u_pick (
    .req_i        ({req1, req0}),
    .last_owner_i (last_owner_q),
    .pick_o       (pick_d)
  );

  assign sel_we_d    = pick_d[P_LOAD] ? we1    : we0;
  assign sel_addr_d  = pick_d[P_LOAD] ? addr1  : addr0;
  assign sel_wdata_d = pick_d[P_LOAD] ? wdata1 : wdata0;

  // NOTE: every register below is assigned with <= so all of them update
  // together from the pre-edge values; blocking = here would chain them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      last_owner_q <= 1'b1;
      gnt_q        <= 2'b00;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      // NOTE: the read-data holding registers are plain flops, not a memory
      // array, so they are cleared with everything else.
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|pick_d) begin
            gnt_q       <= pick_d;
            owner_q     <= pick_d[P_LOAD];
            we_q        <= sel_we_d;
            mem_addr_q  <= sel_addr_d;
            mem_wdata_q <= sel_wdata_d;
            mem_rd_q    <= !sel_we_d;
            mem_wr_q    <= sel_we_d;
            cnt_q       <= WAIT_INIT;
            state_q     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt_q == 4'd0) begin
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            if (!we_q) begin
              if (owner_q) rdata1_q <= mem_rdata;
              else         rdata0_q <= mem_rdata;
            end
            ack0_q  <= !owner_q;
            ack1_q  <= owner_q;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_DONE: begin
          gnt_q        <= 2'b00;
          last_owner_q <= owner_q;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign gnt       = gnt_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a WAIT_CYCLES=1 instance with a
// memory model and scoreboard, plus a WAIT_CYCLES=0 instance.
module tb_mem_bus_arbiter;

  localparam int WAIT_A = 1;

  typedef struct {
    logic        port;
    logic        we;
    logic [12:0] addr;
    logic [7:0]  data;
  } exp_t;

  typedef struct {
    logic        port;
    logic        we;
    logic [12:0] addr;
    logic [7:0]  wdata;
    logic        pre;
    logic [7:0]  pre_data;
    logic [7:0]  exp_rdata;
  } vec_t;

  logic clk;
  logic reset;

  logic        a_req0, a_we0, a_req1, a_we1;
  logic [12:0] a_addr0, a_addr1;
  logic [7:0]  a_wdata0, a_wdata1;
  logic        a_ack0, a_ack1;
  logic [7:0]  a_rdata0, a_rdata1;
  logic [1:0]  a_gnt;
  logic        a_mem_rd, a_mem_wr;
  logic [12:0] a_mem_addr;
  logic [7:0]  a_mem_wdata, a_mem_rdata;

  logic        b_req0;
  logic [12:0] b_addr0;
  logic        b_ack0, b_ack1;
  logic [7:0]  b_rdata0, b_rdata1;
  logic [1:0]  b_gnt;
  logic        b_mem_rd, b_mem_wr;
  logic [12:0] b_mem_addr;
  logic [7:0]  b_mem_wdata, b_mem_rdata;

  logic [7:0]  mem [0:8191];
  logic        pl_en;
  logic [12:0] pl_addr;
  logic [7:0]  pl_data;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   run     = 0;

  mem_bus_arbiter #(.AW(13), .DW(8), .WAIT_CYCLES(WAIT_A)) u_dut_a (
    .clk(clk), .reset(reset),
    .req0(a_req0), .we0(a_we0), .addr0(a_addr0), .wdata0(a_wdata0),
    .ack0(a_ack0), .rdata0(a_rdata0),
    .req1(a_req1), .we1(a_we1), .addr1(a_addr1), .wdata1(a_wdata1),
    .ack1(a_ack1), .rdata1(a_rdata1),
    .gnt(a_gnt), .mem_rd(a_mem_rd), .mem_wr(a_mem_wr),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  mem_bus_arbiter #(.AW(13), .DW(8), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .reset(reset),
    .req0(b_req0), .we0(1'b0), .addr0(b_addr0), .wdata0(8'h00),
    .ack0(b_ack0), .rdata0(b_rdata0),
    .req1(1'b0), .we1(1'b0), .addr1(13'h0000), .wdata1(8'h00),
    .ack1(b_ack1), .rdata1(b_rdata1),
    .gnt(b_gnt), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: backdoor preload or DUT write, one port, async read.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (a_mem_wr) mem[a_mem_addr] <= a_mem_wdata;
  end
  assign a_mem_rdata = mem[a_mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Strobe/ack monitor against the scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      run = 0;
    end else begin
      check("rd_wr_exclusive", 32'(a_mem_rd & a_mem_wr), 32'h0);
      check("ack_exclusive", 32'(a_ack0 & a_ack1), 32'h0);
      if (a_mem_rd | a_mem_wr) begin
        run++;
        if (sb_q.size() != 0) begin
          check("strobe_addr", 32'(a_mem_addr), 32'(sb_q[0].addr));
          check("strobe_kind", 32'(a_mem_wr), 32'(sb_q[0].we));
          if (a_mem_wr) check("strobe_wdata", 32'(a_mem_wdata), 32'(sb_q[0].data));
        end
      end else if (run != 0) begin
        check("strobe_len", 32'(run), 32'(WAIT_A + 1));
        run = 0;
      end
      if (a_ack0 | a_ack1) begin
        check("ack_expected", 32'(sb_q.size() != 0), 32'h1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("ack_port", 32'(a_ack1), 32'(e.port));
          if (!e.we) check("ack_rdata", 32'(e.port ? a_rdata1 : a_rdata0), 32'(e.data));
        end
      end
    end
  end

  task automatic preload(input logic [12:0] addr, input logic [7:0] data);
    pl_en = 1'b1; pl_addr = addr; pl_data = data;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // One access from IDLE; returns one cycle into IDLE after the ack.
  task automatic do_txn(input logic port, input logic we, input logic [12:0] addr,
                        input logic [7:0] wdata);
    int lat = 99;
    if (port) begin a_req1 = 1'b1; a_we1 = we; a_addr1 = addr; a_wdata1 = wdata; end
    else      begin a_req0 = 1'b1; a_we0 = we; a_addr0 = addr; a_wdata0 = wdata; end
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) check("gnt_access", 32'(a_gnt), port ? 32'h2 : 32'h1);
      if (port ? a_ack1 : a_ack0) begin lat = i; break; end
    end
    check("ack_latency", 32'(lat), 32'(WAIT_A + 2));
    a_req0 = 1'b0; a_req1 = 1'b0;
    @(posedge clk); #1;
    check("gnt_idle", 32'(a_gnt), 32'h0);
  endtask

  initial begin
    vec_t vecs[7];
    logic [7:0] keep0, keep1;
    int k, prev, lat;

    vecs[0] = '{port:1'b0, we:1'b0, addr:13'h00A5, wdata:8'h00, pre:1'b1, pre_data:8'h3C, exp_rdata:8'h3C};
    vecs[1] = '{port:1'b1, we:1'b1, addr:13'h1FFF, wdata:8'hA5, pre:1'b0, pre_data:8'h00, exp_rdata:8'h00};
    vecs[2] = '{port:1'b1, we:1'b0, addr:13'h1FFF, wdata:8'h00, pre:1'b0, pre_data:8'h00, exp_rdata:8'hA5};
    vecs[3] = '{port:1'b0, we:1'b1, addr:13'h0000, wdata:8'h5A, pre:1'b1, pre_data:8'h11, exp_rdata:8'h00};
    vecs[4] = '{port:1'b0, we:1'b0, addr:13'h0000, wdata:8'h00, pre:1'b0, pre_data:8'h00, exp_rdata:8'h5A};
    vecs[5] = '{port:1'b1, we:1'b0, addr:13'h00A5, wdata:8'h00, pre:1'b0, pre_data:8'h00, exp_rdata:8'h3C};
    vecs[6] = '{port:1'b0, we:1'b0, addr:13'h1000, wdata:8'h00, pre:1'b1, pre_data:8'hC3, exp_rdata:8'hC3};

    reset = 1'b1;
    a_req0 = 1'b0; a_we0 = 1'b0; a_addr0 = '0; a_wdata0 = '0;
    a_req1 = 1'b0; a_we1 = 1'b0; a_addr1 = '0; a_wdata1 = '0;
    b_req0 = 1'b0; b_addr0 = '0; b_mem_rdata = 8'h00;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;

    #2 reset = 1'b0;
    @(posedge clk); #1;
    check("rst_gnt", 32'(a_gnt), 32'h0);
    check("rst_strobes", 32'({a_mem_rd, a_mem_wr}), 32'h0);
    check("rst_acks", 32'({a_ack0, a_ack1}), 32'h0);
    check("rst_addr", 32'(a_mem_addr), 32'h0);
    check("rst_rdata", 32'({a_rdata0, a_rdata1}), 32'h0);
    @(posedge clk); #1 reset = 1'b1;

    // Single accesses from the vector table.
    foreach (vecs[i]) begin
      if (vecs[i].pre) preload(vecs[i].addr, vecs[i].pre_data);
      sb_q.push_back('{port:vecs[i].port, we:vecs[i].we, addr:vecs[i].addr,
                       data:(vecs[i].we ? vecs[i].wdata : vecs[i].exp_rdata)});
      keep0 = a_rdata0; keep1 = a_rdata1;
      do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].we) begin
        check("write_mem", 32'(mem[vecs[i].addr]), 32'(vecs[i].wdata));
        check("write_keeps_rdata", 32'({a_rdata0, a_rdata1}), 32'({keep0, keep1}));
      end else begin
        check("read_holds", 32'(vecs[i].port ? a_rdata1 : a_rdata0), 32'(vecs[i].exp_rdata));
      end
    end

    // Both ports held high after reset: strict 0,1,0,1 with fixed spacing.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      sb_q.push_back('{port:1'b0, we:1'b0, addr:13'h00A5, data:8'h3C});
      sb_q.push_back('{port:1'b1, we:1'b0, addr:13'h1000, data:8'hC3});
    end
    a_we0 = 1'b0; a_addr0 = 13'h00A5; a_we1 = 1'b0; a_addr1 = 13'h1000;
    a_req0 = 1'b1; a_req1 = 1'b1;
    k = 0; prev = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (a_ack0 | a_ack1) begin
        check("alt_order", 32'(a_ack1), 32'(k % 2));
        if (k == 0) check("alt_first_latency", 32'(c), 32'(WAIT_A + 2));
        else        check("alt_spacing", 32'(c - prev), 32'(WAIT_A + 3));
        prev = c;
        k++;
        if (k == 4) begin a_req0 = 1'b0; a_req1 = 1'b0; break; end
      end
    end
    check("alt_count", 32'(k), 32'h4);
    a_req0 = 1'b0; a_req1 = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Address changes and req drops mid-access: latched values win.
    preload(13'h0010, 8'h77);
    preload(13'h0020, 8'h88);
    sb_q.push_back('{port:1'b0, we:1'b0, addr:13'h0010, data:8'h77});
    a_we0 = 1'b0; a_addr0 = 13'h0010; a_req0 = 1'b1;
    @(posedge clk); #1;
    a_addr0 = 13'h0020; a_req0 = 1'b0;
    #1 check("addr_hold", 32'(a_mem_addr), 32'h0010);
    lat = 99;
    for (int i = 2; i <= 20; i++) begin
      @(posedge clk); #1;
      if (a_ack0) begin lat = i; break; end
    end
    check("drop_req_latency", 32'(lat), 32'(WAIT_A + 2));
    check("addr_change_rdata", 32'(a_rdata0), 32'h77);
    @(posedge clk); #1;

    // Reset in the middle of a strobe aborts the access silently.
    sb_q.push_back('{port:1'b0, we:1'b0, addr:13'h00A5, data:8'h3C});
    a_we0 = 1'b0; a_addr0 = 13'h00A5; a_req0 = 1'b1;
    @(posedge clk); #1;
    check("pre_abort_rd", 32'(a_mem_rd), 32'h1);
    reset = 1'b0;
    #1;
    check("abort_outputs", 32'({a_mem_rd, a_mem_wr, a_gnt, a_ack0, a_ack1}), 32'h0);
    sb_q.delete();
    a_req0 = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    k = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (a_ack0 | a_ack1) k++;
    end
    check("no_ack_after_abort", 32'(k), 32'h0);
    sb_q.push_back('{port:1'b0, we:1'b0, addr:13'h00A5, data:8'h3C});
    do_txn(1'b0, 1'b0, 13'h00A5, 8'h00);
    check("post_abort_rdata", 32'(a_rdata0), 32'h3C);
    check("sb_drained", 32'(sb_q.size()), 32'h0);

    // Zero-wait instance: one-cycle strobe, ack two edges after the request.
    b_mem_rdata = 8'hFF; b_addr0 = 13'h0055; b_req0 = 1'b1;
    @(posedge clk); #1;
    check("w0_strobe", 32'({b_mem_rd, b_mem_wr, b_ack0}), 32'h4);
    check("w0_addr", 32'(b_mem_addr), 32'h0055);
    @(posedge clk); #1;
    check("w0_ack", 32'({b_mem_rd, b_ack0, b_ack1}), 32'h2);
    check("w0_rdata", 32'(b_rdata0), 32'hFF);
    b_req0 = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("w0_idle", 32'({b_gnt, b_ack0}), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1);
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 8-bit data / 13-bit address memory port between two requesters: port 0 is the CPU bus (rd/wr/addr/data) and port 1 is the program loader / DMA.
- Sequences each access with a programmable wait-state count and returns read data with a one-cycle ack.
- Uses round-robin arbitration so neither port starves.
- Sits between cpu and the memory model; tristating of the shared memory data bus is done outside this block.

Parameters:
- AW, 13, address width
- DW, 8, data width
- WAIT_CYCLES, 1, extra memory cycles per access (0..15); an access strobe lasts WAIT_CYCLES+1 cycles

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req0  input  1  port 0 (CPU) request; held until ack0
- we0  input  1  port 0 write enable (1=write, 0=read)
- addr0  input  AW  port 0 address
- wdata0  input  DW  port 0 write data
- ack0  output  1  port 0 one-cycle completion pulse
- rdata0  output  DW  port 0 read data, valid while ack0=1
- req1, we1, addr1, wdata1  input  1/1/AW/DW  port 1 equivalents
- ack1  output  1  port 1 completion pulse
- rdata1  output  DW  port 1 read data
- gnt  output  2  one-hot owner of the current access (00 when idle)
- mem_rd  output  1  memory read strobe
- mem_wr  output  1  memory write strobe
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, last_owner=1 (so port 0 wins first), all outputs 0, wait counter 0. Reset mid-access aborts it; no ack is issued.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No req: stay in IDLE, gnt=00.
  - Exactly one req: grant that port.
  - Both req: grant the port that is not last_owner.
  - On grant (registered at the clock edge): gnt set one-hot; mem_addr/mem_wdata/we latched from the granted port; counter=WAIT_CYCLES; go to ACCESS.
- ACCESS:
  - mem_rd=~we or mem_wr=we, asserted for exactly WAIT_CYCLES+1 cycles. mem_addr/mem_wdata stay stable for the whole strobe.
  - Counter decrements each cycle.
  - On the cycle the counter reaches 0: read data captured from mem_rdata into that port's rdata register; go to DONE.
- DONE:
  - mem_rd=mem_wr=0; ack of the owner port =1 for one cycle; rdata valid this cycle.
  - last_owner updated; gnt cleared at the next edge; next state IDLE.
- Latency: from req sampled in IDLE to ack = WAIT_CYCLES+2 cycles. Back-to-back accesses cost one IDLE cycle between them, so throughput is one access per WAIT_CYCLES+3 cycles.
- Requesters deassert req in the cycle after ack. A req still high in IDLE after ack is treated as a new request.
- A req that drops during ACCESS does not abort: the access completes and ack is still pulsed.
- Input changes on addr/wdata/we during ACCESS are ignored because the values are latched at grant.
- rdata0/rdata1 hold their last read value; writes do not update them.
- Simultaneous requests with alternating traffic alternate strictly: 0,1,0,1…
- mem_rd and mem_wr are never both 1. At most one ack is high per cycle.
- WAIT_CYCLES=0 gives a single-cycle strobe.

Decomposition:
- Shared package `bus_pkg`:
  - FSM state encoding constants ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_DONE=2'd2
  - AW/DW defaults
  - port index constants P_CPU=0, P_LOAD=1
- One natural sub-module, `rr_pick2`: a 2-way round-robin selector taking req[1:0] and last_owner, producing a one-hot pick. Everything else stays in the top module.

Test Plan:
- Reset, then a single port-0 read at addr 13'h0A5 with mem holding 8'h3C, WAIT_CYCLES=1 -> mem_rd high exactly 2 cycles with mem_addr=13'h0A5; ack0 pulses at cycle 3 after req; rdata0=8'h3C; gnt=01 during ACCESS.
- Port-1 write addr 13'h1FFF, data 8'hA5 -> mem_wr high 2 cycles; mem_addr=13'h1FFF, mem_wdata=8'hA5; ack1 single pulse; rdata1 unchanged.
- req0 and req1 both held high continuously after reset -> grant order 0,1,0,1; ack pulses alternate; each ack is spaced WAIT_CYCLES+3 cycles from the previous one.
- Port 0 changes addr0 from 13'h010 to 13'h020 mid-ACCESS -> mem_addr stays 13'h010 through the strobe.
- reset asserted during ACCESS -> mem_rd/mem_wr/gnt/acks go to 0 immediately; no ack after release; next req0 is served normally.
- Rebuild with WAIT_CYCLES=0 and read 8'hFF -> one-cycle mem_rd; ack0 two cycles after req; rdata0=8'hFF.
